// File: rtl/pwm_pkg.sv
// pwm_pkg: shared width formulas and duty clamp for the PWM generator and its divider peers.
package pwm_pkg;

    function automatic int cnt_width(input int period);
        return $clog2(period);
    endfunction

    function automatic int duty_width(input int period);
        return $clog2(period + 1);
    endfunction

    function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// rise_edge_detect: one-cycle pulse on each rising edge of a clk-synchronous slow signal.
module rise_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);
    logic sig_q;
    logic sig_d;

    always_comb sig_d = sig;

    always_ff @(posedge clk) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_d;
    end

    assign rise = sig & ~sig_q;
endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: PERIOD-tick PWM driven by divided-clock edges, with a double-buffered duty handshake.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter  int PERIOD = 8,
    localparam int CNT_W  = cnt_width(PERIOD),
    localparam int DUTY_W = duty_width(PERIOD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_clk,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              period_done
);
    logic              tick;
    logic              wrap;
    logic              accept;
    logic              xfer;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DUTY_W-1:0] duty_act_q, duty_act_d;
    logic [DUTY_W-1:0] duty_shadow_q, duty_shadow_d;
    logic              pending_q, pending_d;
    logic              pwm_q, pwm_d;
    logic              done_q, done_d;

    rise_edge_detect u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (div_clk),
        .rise (tick)
    );

    always_comb begin
        wrap          = tick & en & (cnt_q == CNT_W'(PERIOD - 1));
        accept        = duty_valid & ~pending_q;
        // While stopped, a pending duty is applied immediately so it can be set up before start.
        xfer          = pending_q & (en ? wrap : 1'b1);
        cnt_d         = (tick & en) ? (wrap ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        duty_shadow_d = accept ? DUTY_W'(clamp_duty(32'(duty_in), PERIOD)) : duty_shadow_q;
        duty_act_d    = xfer ? duty_shadow_q : duty_act_q;
        pending_d     = accept ? 1'b1 : (xfer ? 1'b0 : pending_q);
        pwm_d         = DUTY_W'(cnt_q) < duty_act_q;
        done_d        = wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            duty_act_q    <= '0;
            duty_shadow_q <= '0;
            pending_q     <= 1'b0;
            pwm_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            duty_act_q    <= duty_act_d;
            duty_shadow_q <= duty_shadow_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            done_q        <= done_d;
        end
    end

    assign duty_ready  = ~pending_q;
    assign pwm_out     = pwm_q;
    assign period_done = done_q;
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed checks of the PWM generator with PERIOD=4 and a divide-by-4 tick source.
module tb_pwm_generator;
    localparam int P  = 4;
    localparam int CW = $clog2(P);
    localparam int DW = $clog2(P + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          div_clk = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] duty_in = '0;
    logic          duty_valid = 1'b0;
    logic          duty_ready;
    logic          pwm_out;
    logic          period_done;

    int   checks = 0;
    int   errors = 0;
    bit   div_run = 1'b0;
    logic [1:0] dcnt = 2'd0;

    pwm_generator #(.PERIOD(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_clk    (div_clk),
        .en         (en),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_done(period_done)
    );

    always #5 clk = ~clk;

    // Upstream divide-by-4: high 2 clk, low 2 clk.
    always @(negedge clk) begin
        if (div_run) begin
            dcnt    = dcnt + 2'd1;
            div_clk = dcnt[1];
        end
    end

    task automatic window(input int n, output int highs, output int dones);
        highs = 0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            highs += int'(pwm_out === 1'b1);
            dones += int'(period_done === 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic offer(input int d, output int waited);
        bit ok;
        ok         = 1'b0;
        waited     = 0;
        duty_in    = DW'(d);
        duty_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (duty_ready === 1'b1) begin
                ok     = 1'b1;
                waited = i;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        duty_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL offer_accept: duty %0d never accepted within 100 clk", d);
        end
    endtask

    task automatic wait_cnt(input int v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (dut.cnt_q === CW'(v)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_cnt: cnt never reached %0d within 64 clk", v);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        div_run = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", period_done); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", duty_ready); end
        checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
    endtask

    task automatic test_preload;
        int h, d;
        rst_n      = 1'b1;
        en         = 1'b0;
        duty_in    = DW'(1);
        duty_valid = 1'b1;
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL preload_ready0: got %b want 1", duty_ready); end
        @(negedge clk);
        duty_valid = 1'b0;
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL preload_ready1: got %b want 0", duty_ready); end
        @(negedge clk);
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL preload_ready2: got %b want 1", duty_ready); end
        checks++; if (dut.duty_act_q !== DW'(1)) begin errors++; $display("FAIL preload_act: got %0d want 1", dut.duty_act_q); end
        repeat (8) @(negedge clk);
        checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL preload_hold: got cnt %0d want 0", dut.cnt_q); end
        en = 1'b1;
        repeat (32) @(negedge clk);
        window(32, h, d);
        checks++; if (h != 8) begin errors++; $display("FAIL preload_highs: got %0d want 8", h); end
        checks++; if (d != 2) begin errors++; $display("FAIL preload_done: got %0d want 2", d); end
    endtask

    task automatic test_extremes;
        int h, d, w;
        offer(0, w);
        repeat (24) @(negedge clk);
        window(16, h, d);
        checks++; if (h != 0) begin errors++; $display("FAIL duty0_highs: got %0d want 0", h); end
        checks++; if (d != 1) begin errors++; $display("FAIL duty0_done: got %0d want 1", d); end
        offer(7, w);
        repeat (24) @(negedge clk);
        checks++; if (dut.duty_act_q !== DW'(4)) begin errors++; $display("FAIL clamp_act: got %0d want 4", dut.duty_act_q); end
        window(16, h, d);
        checks++; if (h != 16) begin errors++; $display("FAIL duty7_highs: got %0d want 16", h); end
        checks++; if (d != 1) begin errors++; $display("FAIL duty7_done: got %0d want 1", d); end
    endtask

    task automatic test_back_to_back;
        int h, d, w;
        offer(1, w);
        repeat (40) @(negedge clk);
        wait_cnt(0);
        wait_cnt(1);
        offer(3, w);
        checks++; if (w != 0) begin errors++; $display("FAIL b2b_first_wait: got %0d want 0", w); end
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", duty_ready); end
        offer(2, w);
        checks++; if (w != 11) begin errors++; $display("FAIL b2b_stall: got %0d want 11", w); end
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL b2b_pending2: got %b want 0", duty_ready); end
        window(16, h, d);
        checks++; if (h != 12) begin errors++; $display("FAIL b2b_duty3_highs: got %0d want 12", h); end
        checks++; if (d != 1) begin errors++; $display("FAIL b2b_duty3_done: got %0d want 1", d); end
        window(16, h, d);
        checks++; if (h != 8) begin errors++; $display("FAIL b2b_duty2_highs: got %0d want 8", h); end
        checks++; if (d != 1) begin errors++; $display("FAIL b2b_duty2_done: got %0d want 1", d); end
    endtask

    task automatic test_reset_mid;
        int h, d, w;
        offer(4, w);
        repeat (40) @(negedge clk);
        offer(1, w);
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL mid_pending: got %b want 0", duty_ready); end
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL mid_pwm_high: got %b want 1", pwm_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL mid_sync_pwm: got %b want 1", pwm_out); end
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL mid_sync_ready: got %b want 0", duty_ready); end
        @(negedge clk);
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL mid_rst_pwm: got %b want 0", pwm_out); end
        checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", period_done); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", duty_ready); end
        checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", dut.cnt_q); end
        checks++; if (dut.duty_act_q !== '0) begin errors++; $display("FAIL mid_rst_act: got %0d want 0", dut.duty_act_q); end
        checks++; if (dut.duty_shadow_q !== '0) begin errors++; $display("FAIL mid_rst_shadow: got %0d want 0", dut.duty_shadow_q); end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        window(16, h, d);
        checks++; if (h != 0) begin errors++; $display("FAIL mid_discard_highs: got %0d want 0", h); end
        checks++; if (d != 1) begin errors++; $display("FAIL mid_discard_done: got %0d want 1", d); end
    endtask

    task automatic test_div_stuck;
        int h, d, w, changes;
        logic p0;
        logic [CW-1:0] c0;
        offer(2, w);
        repeat (40) @(negedge clk);
        div_run = 1'b0;
        div_clk = 1'b1;
        repeat (3) @(negedge clk);
        p0 = pwm_out;
        c0 = dut.cnt_q;
        changes = 0;
        for (int i = 0; i < 37; i++) begin
            if (pwm_out !== p0) changes++;
            @(negedge clk);
        end
        checks++; if (changes != 0) begin errors++; $display("FAIL stuck_pwm: got %0d changes want 0", changes); end
        checks++; if (dut.cnt_q !== c0) begin errors++; $display("FAIL stuck_cnt: got %0d want %0d", dut.cnt_q, c0); end
        div_run = 1'b1;
        repeat (32) @(negedge clk);
        window(16, h, d);
        checks++; if (h != 8) begin errors++; $display("FAIL resume_highs: got %0d want 8", h); end
        checks++; if (d != 1) begin errors++; $display("FAIL resume_done: got %0d want 1", d); end
    endtask

    initial begin
        test_reset;
        test_preload;
        test_extremes;
        test_back_to_back;
        test_reset_mid;
        test_div_stuck;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Downstream consumer of the basic clock divider's square-wave output.
- Detects rising edges of the divided clock (a slow signal, synchronous to the system clock) and uses each edge as a count tick.
- Generates a PWM waveform of PERIOD ticks with a programmable duty.
- Duty updates arrive through a valid/ready handshake; they are double-buffered and applied only at a period boundary, so no glitched periods occur.

Parameters:
- PERIOD, 8: PWM period in ticks. Must be ≥ 2.
- CNT_W, $clog2(PERIOD): localparam, tick counter width.
- DUTY_W, $clog2(PERIOD+1): localparam, duty width; can represent 0..PERIOD.

Ports:
- clk, input, 1: system clock. All logic runs on its rising edge.
- rst_n, input, 1: reset. Synchronous, active-low.
- div_clk, input, 1: divided clock from the upstream divider, synchronous to clk.
- en, input, 1: run enable. When 0, the counter holds.
- duty_in, input, DUTY_W: requested duty, in ticks high per period.
- duty_valid, input, 1: duty_in is offered.
- duty_ready, output, 1: block can accept a duty value.
- pwm_out, output, 1: PWM waveform, registered.
- period_done, output, 1: one-clk pulse, one cycle after each period wrap.

Behaviour:
- Reset:
  - Takes effect when rst_n=0 at a clk posedge. It is not asynchronous; outputs keep their values until that edge.
  - Reset values: pwm_out=0, period_done=0, duty_ready=1, cnt=0, duty_act=0, duty_shadow=0, pending=0, div_q=0.
  - While rst_n=0, everything stays in reset state regardless of other inputs.
- Edge detect:
  - div_q <= div_clk every cycle.
  - tick = div_clk & ~div_q, combinational.
  - If div_clk is high on the first cycle after reset, exactly one tick is produced. This is intended.
  - div_clk held constant produces no ticks.
- Counter:
  - Advances only when tick & en.
  - Wraps from PERIOD-1 to 0.
  - The wrap event is wrap = tick & en & (cnt == PERIOD-1).
- period_done:
  - Registered: period_done <= wrap, giving exactly a 1-cycle pulse.
- pwm_out:
  - pwm_out <= (cnt < duty_act), evaluated every clk, using values before this edge's update.
  - Latency is 1 clk after a cnt or duty_act change.
  - duty_act=0 gives a constant 0 output.
  - duty_act=PERIOD gives a constant 1 output.
- Duty handshake:
  - duty_ready = ~pending, driven combinationally from a register.
  - Accept occurs when duty_valid & duty_ready.
  - On accept: duty_shadow <= min(duty_in, PERIOD) (values are clamped), and pending <= 1.
  - duty_in is ignored when not accepted.
  - The producer must hold duty_valid/duty_in until it is accepted.
- Transfer of shadow to active duty:
  - When en=1: on wrap with pending=1, duty_act <= duty_shadow and pending <= 0. The new duty governs the very next period (cnt=0 onward).
  - When en=0: if pending=1, the transfer happens at the next clk regardless of ticks. This allows configuration before start.
- Simultaneous accept and wrap in the same cycle:
  - pending was 0, so no transfer occurs on that wrap.
  - The accepted value waits for the following wrap (or for the en=0 path).
- Disabling and re-enabling:
  - en falling mid-period freezes cnt; pwm_out holds at the comparison of the frozen cnt.
  - en rising resumes from the frozen cnt. There is no restart.

Decomposition:
- Package pwm_pkg holds a function clamp_duty and the shared localparam formulas for CNT_W and DUTY_W, so the upstream divider's testbench and this block agree on widths.
- One natural sub-module: rise_edge_detect, a 1-bit register plus AND that produces the tick. It is reusable for other divider consumers.
- Counter, handshake and comparator remain in the top module.

Test Plan:
All tests use PERIOD=4 and div_clk driven by a divider with DIVISOR=4, giving a rising edge every 4 clk, so one PWM period is 16 clk.
1. Reset: rst_n=0 for 3 clk with div_clk toggling and en=1 -> pwm_out=0, period_done=0, duty_ready=1, no counting. A mid-cycle rst_n drop does not change outputs before the next posedge.
2. Preload: en=0, duty_in=1 valid for 1 clk -> duty_ready low for 1 clk then 1. Raise en -> pwm_out high for 4 clk out of every 16; period_done pulses every 16 clk.
3. Extremes: duty 0 -> pwm_out constantly 0. duty 7 (clamped to 4) -> pwm_out constantly 1. period_done still pulses every 16 clk.
4. Mid-period update at duty 1, en=1: offer duty 3 at cnt=1 -> duty_ready=0 until the wrap. The next period has 12 clk high. A second offer (duty 2) made while ready=0 stalls until after that wrap and takes effect one period later.
5. Reset mid-operation while pwm_out=1 and pending=1 -> at the next posedge all outputs and state return to reset values; the pending duty is discarded.
6. div_clk held at 1 for 40 clk with en=1 -> at most one tick (at start), then cnt frozen and pwm_out constant. Resuming toggling restores normal 16-clk periods.
